// File: rtl/seg7_scan_decoder.sv
// Monitor for a multiplexed 4-digit 7-segment bus.
// It rebuilds the displayed hex value and flags glitches, illegal segment patterns and bus inactivity.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        an0,
   input  logic        an1,
   input  logic        an2,
   input  logic        an3,
   input  logic [6:0]  cathode,
   input  logic        dp,
   output logic [15:0] value,
   output logic [3:0]  dp_mask,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        seg_err,
   output logic        multi_err,
   output logic        stale
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   // Idle bus: all anodes off, all segments off, dp off.
   localparam logic [11:0] SNAP_IDLE = 12'hFFF;

   // Returns {legal, nibble} for an active-low {g,f,e,d,c,b,a} pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [11:0]      snap_q, snap_d, prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       captured_q, captured_d;
   logic [15:0]      scratch_q, scratch_d;
   logic [3:0]       scratch_dp_q, scratch_dp_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [15:0]      value_q, value_d;
   logic [3:0]       dp_mask_q, dp_mask_d;
   logic [3:0]       digit_valid_q, digit_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             seg_err_q, seg_err_d;
   logic             multi_err_q, multi_err_d;
   logic             stale_q, stale_d;

   logic       stable, fire, one_hot, legal_cap, illegal_cap, complete;
   logic [3:0] an_low;
   logic [1:0] idx;
   logic [4:0] dec;

   always_comb begin
      snap_d = {an3, an2, an1, an0, cathode, dp};
      prev_d = snap_q;
      stable = (snap_q == prev_q);

      if (!stable)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = cnt_q;

      // Saturation at CNT_MAX makes this fire once per stable period.
      fire = stable && (cnt_q == CNT_FIRE);

      an_low  = ~snap_q[11:8];
      dec     = seg_decode(snap_q[7:1]);
      idx     = 2'd0;
      one_hot = 1'b0;
      case (an_low)
         4'b0001: begin idx = 2'd0; one_hot = 1'b1; end
         4'b0010: begin idx = 2'd1; one_hot = 1'b1; end
         4'b0100: begin idx = 2'd2; one_hot = 1'b1; end
         4'b1000: begin idx = 2'd3; one_hot = 1'b1; end
         default: begin idx = 2'd0; one_hot = 1'b0; end
      endcase

      legal_cap   = fire && one_hot && dec[4];
      illegal_cap = fire && one_hot && !dec[4];
      complete    = (captured_q == 4'hF);

      captured_d    = complete ? 4'h0 : captured_q;
      scratch_d     = scratch_q;
      scratch_dp_d  = scratch_dp_q;
      digit_valid_d = digit_valid_q;
      if (legal_cap) begin
         scratch_d[{idx, 2'b00} +: 4] = dec[3:0];
         scratch_dp_d[idx]            = ~snap_q[0];
         digit_valid_d[idx]           = 1'b1;
         captured_d[idx]              = 1'b1;
      end else if (illegal_cap) begin
         digit_valid_d[idx] = 1'b0;
         captured_d[idx]    = 1'b0;
      end

      value_d      = complete ? scratch_q : value_q;
      dp_mask_d    = complete ? scratch_dp_q : dp_mask_q;
      frame_done_d = complete;
      seg_err_d    = illegal_cap;
      multi_err_d  = fire && (an_low != 4'h0) && !one_hot;

      if (legal_cap)
         tmo_d = '0;
      else if (tmo_q != TMO_MAX)
         tmo_d = tmo_q + 1'b1;
      else
         tmo_d = tmo_q;
      stale_d = (tmo_d == TMO_MAX);
   end

   // Snapshot history resets to the idle pattern with the counter saturated,
   // so coming out of reset never produces a spurious event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q        <= SNAP_IDLE;
         prev_q        <= SNAP_IDLE;
         cnt_q         <= CNT_MAX;
         captured_q    <= '0;
         scratch_q     <= '0;
         scratch_dp_q  <= '0;
         tmo_q         <= '0;
         value_q       <= '0;
         dp_mask_q     <= '0;
         digit_valid_q <= '0;
         frame_done_q  <= 1'b0;
         seg_err_q     <= 1'b0;
         multi_err_q   <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         snap_q        <= snap_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         captured_q    <= captured_d;
         scratch_q     <= scratch_d;
         scratch_dp_q  <= scratch_dp_d;
         tmo_q         <= tmo_d;
         value_q       <= value_d;
         dp_mask_q     <= dp_mask_d;
         digit_valid_q <= digit_valid_d;
         frame_done_q  <= frame_done_d;
         seg_err_q     <= seg_err_d;
         multi_err_q   <= multi_err_d;
         stale_q       <= stale_d;
      end
   end

   assign value       = value_q;
   assign dp_mask     = dp_mask_q;
   assign digit_valid = digit_valid_q;
   assign frame_done  = frame_done_q;
   assign seg_err     = seg_err_q;
   assign multi_err   = multi_err_q;
   assign stale       = stale_q;

endmodule
